// File: rtl/fp_align_stage.sv
// FP adder front end: unpacks two singles, orders them by magnitude and
// right-aligns the smaller significand with guard/round/sticky over two stages.
module fp_align_stage #(
    parameter int SHIFT_W = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        outValid,
    input  logic        outReady,
    output logic        eop,
    output logic        aSign,
    output logic        bSign,
    output logic        aExpIsSmall,
    output logic [7:0]  bigExp,
    output logic [23:0] bigMant,
    output logic [SHIFT_W-1:0] smallMant,
    output logic        special
);
    localparam int STAGES = 2;
    localparam logic [7:0] SHIFT_LIM = 8'(SHIFT_W);

    typedef struct packed {
        logic        eop;
        logic        asign;
        logic        bsign;
        logic        asmall;
        logic        special;
        logic [7:0]  bigexp;
        logic [23:0] bigmant;
        logic [23:0] smallsig;
        logic [7:0]  diff;
    } s1_t;

    logic [STAGES:1] vld_pipe;
    logic            adv2;
    s1_t             s1_d, s1_q;

    logic [7:0]  expa, expb, effa, effb;
    logic [23:0] siga, sigb;
    logic        asmall;

    // Denormals use effective exponent 1 with no hidden bit, so the
    // {exp,sig} concatenation orders magnitudes for every finite input.
    always_comb begin
        expa   = a[30:23];
        expb   = b[30:23];
        effa   = (expa == 8'd0) ? 8'd1 : expa;
        effb   = (expb == 8'd0) ? 8'd1 : expb;
        siga   = {|expa, a[22:0]};
        sigb   = {|expb, b[22:0]};
        asmall = {effa, siga} < {effb, sigb};

        s1_d          = '0;
        s1_d.eop      = a[31] ^ b[31] ^ sub;
        s1_d.asign    = a[31];
        s1_d.bsign    = b[31] ^ sub;
        s1_d.asmall   = asmall;
        s1_d.special  = (expa == 8'hFF) || (expb == 8'hFF);
        s1_d.bigexp   = asmall ? effb : effa;
        s1_d.bigmant  = asmall ? sigb : siga;
        s1_d.smallsig = asmall ? siga : sigb;
        s1_d.diff     = asmall ? (effb - effa) : (effa - effb);
    end

    assign adv2    = !vld_pipe[2] || outReady;
    assign inReady = !vld_pipe[1] || adv2;
    assign outValid = vld_pipe[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            s1_q        <= '0;
        end else if (inReady) begin
            vld_pipe[1] <= inValid;
            if (inValid)
                s1_q <= s1_d;
        end
    end

    logic [SHIFT_W-1:0] ext, shifted, mask, align;

    // Anything shifted past bit 0 collapses into the sticky bit.
    always_comb begin
        ext     = {s1_q.smallsig, {(SHIFT_W-24){1'b0}}};
        shifted = '0;
        mask    = '0;
        if (s1_q.diff >= SHIFT_LIM) begin
            align = {{(SHIFT_W-1){1'b0}}, |s1_q.smallsig};
        end else begin
            shifted = ext >> s1_q.diff;
            mask    = ~({SHIFT_W{1'b1}} << s1_q.diff);
            align   = shifted | {{(SHIFT_W-1){1'b0}}, |(ext & mask)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            eop         <= 1'b0;
            aSign       <= 1'b0;
            bSign       <= 1'b0;
            aExpIsSmall <= 1'b0;
            special     <= 1'b0;
            bigExp      <= '0;
            bigMant     <= '0;
            smallMant   <= '0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                eop         <= s1_q.eop;
                aSign       <= s1_q.asign;
                bSign       <= s1_q.bsign;
                aExpIsSmall <= s1_q.asmall;
                special     <= s1_q.special;
                bigExp      <= s1_q.bigexp;
                bigMant     <= s1_q.bigmant;
                smallMant   <= align;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: directed vector table, backpressure and reset
// sequences, and random traffic scored against an arithmetic model.
module tb_fp_align_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] a = '0, b = '0;
    logic        sub = 1'b0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic        eop, aSign, bSign, aExpIsSmall, special;
    logic [7:0]  bigExp;
    logic [23:0] bigMant;
    logic [26:0] smallMant;

    fp_align_stage #(.SHIFT_W(27)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .a(a), .b(b), .sub(sub), .outValid(outValid), .outReady(outReady),
        .eop(eop), .aSign(aSign), .bSign(bSign), .aExpIsSmall(aExpIsSmall),
        .bigExp(bigExp), .bigMant(bigMant), .smallMant(smallMant), .special(special)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] q[$];
    wire  [63:0] act = {eop, aSign, bSign, aExpIsSmall, special, bigExp, bigMant, smallMant};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Reference: magnitude compare by exponent then significand; alignment by
    // integer division by 2^d with any remainder becoming the sticky bit.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        int     ex, ey, eb, es, d;
        longint mx, my, mb, ms, v, p, sm;
        logic   xs;
        ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
        mx = longint'(x[22:0]) + ((x[30:23] == 0) ? 0 : 8388608);
        my = longint'(y[22:0]) + ((y[30:23] == 0) ? 0 : 8388608);
        xs = (ex < ey) || (ex == ey && mx < my);
        if (xs) begin eb = ey; mb = my; es = ex; ms = mx; end
        else    begin eb = ex; mb = mx; es = ey; ms = my; end
        d = eb - es;
        if (ms == 0) sm = 0;
        else if (d >= 27) sm = 1;
        else begin
            v = ms * 8;
            p = 1;
            repeat (d) p = p * 2;
            sm = v / p;
            if (v % p != 0) sm = sm | 1;
        end
        return {x[31] ^ y[31] ^ s, x[31], y[31] ^ s, xs,
                (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF), 8'(eb), 24'(mb), 27'(sm)};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (outValid && outReady) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_extra got=%h want=none", act);
                end else begin
                    chk("sb", act, q.pop_front());
                end
            end
            if (inValid && inReady)
                q.push_back(model(a, b, sub));
        end
    end

    typedef struct {
        logic [31:0] a, b;
        logic        sub;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[9];

    function automatic vec_t mk(input logic [31:0] x, y, input logic s, input logic e, as, bs, sm, sp,
                                input logic [7:0] be, input logic [23:0] bm, input logic [26:0] smm);
        vec_t r;
        r.a = x; r.b = y; r.sub = s;
        r.exp = {e, as, bs, sm, sp, be, bm, smm};
        return r;
    endfunction

    task automatic send(input logic [31:0] ta, input logic [31:0] tb2, input logic ts);
        inValid = 1'b1; a = ta; b = tb2; sub = ts;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (inReady) begin
                @(posedge clk); #1;
                inValid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        total++; bad++;
        $display("FAIL send_timeout got=inReady0 want=inReady1");
    endtask

    function automatic logic [31:0] rnd_op(input logic [7:0] near);
        logic [7:0] e;
        int r = $urandom_range(0, 19);
        if (r < 3) e = 8'd0;
        else if (r == 3) e = 8'hFF;
        else if (r < 12) e = 8'(int'(near) + $urandom_range(0, 32) - 16);
        else e = 8'($urandom_range(0, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [31:0] ops_a[4], ops_b[4];
    logic [63:0] snap;
    logic        acc;
    int          k, got;

    initial begin
        tbl[0] = mk(32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 0, 0, 8'd127, 24'h800000, 27'h4000000);
        tbl[1] = mk(32'h3F800000, 32'hC0800000, 0, 1, 0, 1, 1, 0, 8'd129, 24'h800000, 27'h1000000);
        tbl[2] = mk(32'h3F800000, 32'h3FC00000, 1, 1, 0, 1, 1, 0, 8'd127, 24'hC00000, 27'h4000000);
        tbl[3] = mk(32'h3F800001, 32'h4E800000, 0, 0, 0, 0, 1, 0, 8'd157, 24'h800000, 27'h0000001);
        tbl[4] = mk(32'h00000001, 32'h00800000, 0, 0, 0, 0, 1, 0, 8'd1,   24'h800000, 27'h0000008);
        tbl[5] = mk(32'h7F800000, 32'h3F800000, 0, 0, 0, 0, 0, 1, 8'hFF,  24'h800000, 27'h0000001);
        tbl[6] = mk(32'h40000000, 32'h00000000, 0, 0, 0, 0, 0, 0, 8'd128, 24'h800000, 27'h0000000);
        tbl[7] = mk(32'h3F800001, 32'h4B800000, 0, 0, 0, 0, 1, 0, 8'd151, 24'h800000, 27'h0000005);
        tbl[8] = mk(32'hBF800000, 32'h3F800000, 1, 0, 1, 1, 0, 0, 8'd127, 24'h800000, 27'h4000000);

        #1;
        chk("rst_outvalid", 64'(outValid), 64'd0);
        chk("rst_data", act, 64'd0);
        #20;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_inready", 64'(inReady), 64'd1);
        @(posedge clk); #1;

        outReady = 1'b1;
        foreach (tbl[i]) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sub);
            @(negedge clk);
            chk("lat_early", 64'(outValid), 64'd0);
            @(negedge clk);
            chk("lat_two", 64'(outValid), 64'd1);
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
            @(posedge clk); #1;
        end

        // Backpressure: four back-to-back operands against a stalled sink.
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) begin ops_a[i] = rnd_op(8'd127); ops_b[i] = rnd_op(8'd127); end
        k = 0;
        inValid = 1'b1; a = ops_a[0]; b = ops_b[0]; sub = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_inready", 64'(inReady), 64'(k < 2));
            if (c >= 2) begin
                chk("bp_valid", 64'(outValid), 64'd1);
                if (c == 2) snap = act; else chk("bp_hold", act, snap);
            end
            acc = inValid && inReady;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin a = ops_a[k]; b = ops_b[k]; end else inValid = 1'b0;
            end
        end
        outReady = 1'b1;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (outValid) got++;
            acc = inValid && inReady;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin a = ops_a[k]; b = ops_b[k]; end else inValid = 1'b0;
            end
        end
        chk("bp_stream", 64'(got), 64'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drain", 64'(q.size()), 64'd0);

        // Reset with two operands in flight.
        inValid = 1'b1; a = 32'h40400000; b = 32'h3F000000; sub = 1'b1;
        @(posedge clk); #1;
        a = 32'hC1200000; b = 32'h41200000;
        @(posedge clk); #1;
        inValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outvalid", 64'(outValid), 64'd0);
        chk("arst_data", act, 64'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(outValid), 64'd0);
        chk("post_rst_inready", 64'(inReady), 64'd1);
        @(posedge clk); #1;
        send(32'h41200000, 32'h3DCCCCCD, 1'b0);
        @(negedge clk);
        chk("post_rst_early", 64'(outValid), 64'd0);
        @(negedge clk);
        chk("post_rst_lat", 64'(outValid), 64'd1);
        chk("post_rst_val", act, model(32'h41200000, 32'h3DCCCCCD, 1'b0));
        @(posedge clk); #1;

        // Random traffic with random stalls, scored by the monitor.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = inValid && inReady;
            @(posedge clk); #1;
            if (acc || !inValid) begin
                inValid = ($urandom_range(0, 3) != 0);
                a = rnd_op(8'($urandom_range(0, 255)));
                b = rnd_op(a[30:23]);
                sub = 1'($urandom);
            end
            outReady = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        acc = inValid && inReady;
        @(posedge clk); #1;
        if (!acc) begin
            // Keep the pending offer until it is taken, then stop.
            for (int i = 0; i < 10 && inValid; i++) begin
                outReady = 1'b1;
                @(negedge clk);
                acc = inReady;
                @(posedge clk); #1;
                if (acc) inValid = 1'b0;
            end
        end
        inValid = 1'b0;
        outReady = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rand_drain", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Front-end stage of the 32-bit FP adder; sits directly upstream of the result-sign selector and the mantissa add/subtract datapath.
- Unpacks two IEEE-754 single-precision operands and computes the effective operation (eop) and the magnitude-compare flag (aExpIsSmall).
- Swaps the operands so the larger magnitude comes first, then right-aligns the smaller mantissa with guard/round/sticky bits.
- Two-stage pipeline with valid/ready handshake at both ends; full throughput.

Parameters:
- SHIFT_W, 27, width of aligned mantissa (24 significand bits + guard, round, sticky).

Ports:
- clk  input  1  clock; all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- inValid  input  1  input operands valid.
- inReady  output  1  stage can accept this cycle.
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- sub  input  1  1 = A-B, 0 = A+B.
- outValid  output  1  outputs valid.
- outReady  input  1  downstream accepts.
- eop  output  1  effective subtraction.
- aSign  output  1  sign of A.
- bSign  output  1  effective sign of B (b[31]^sub).
- aExpIsSmall  output  1  |A| < |B|.
- bigExp  output  8  biased exponent of larger operand (denormal reported as 1).
- bigMant  output  24  significand of larger operand, hidden bit included.
- smallMant  output  27  aligned smaller significand {sig,3'b0}>>diff, sticky in bit 0.
- special  output  1  either operand has exponent 8'hFF.

Behaviour:
- Reset (async, immediate): both stage-valid registers and all output data registers are 0. In-flight data is discarded. inReady=1 the cycle after reset releases.
- Unpack:
  - exp==0: effective exponent 1, hidden bit 0.
  - Otherwise: hidden bit 1.
- eop = a[31] ^ b[31] ^ sub.
- aExpIsSmall = 1 iff {effExpA,sigA} < {effExpB,sigB} (unsigned). Equal magnitudes give 0.
- Stage 1 registers:
  - eop, aSign, bSign, aExpIsSmall, special.
  - bigExp and bigMant (the larger operand after swap).
  - Small significand and diff = bigEffExp - smallEffExp (8 bits, always >= 0).
- Stage 2: smallMant = ({sig,3'b000} >> min(diff,27)), with bit 0 ORed with the OR of all shifted-out bits.
  - diff >= 27 with nonzero sig: smallMant = 27'd1.
  - sig == 0: smallMant = 0.
- Handshake:
  - Stage k loads when its valid is 0 or the next stage drains that cycle.
  - inReady = !v1 || (!v2 || outReady).
  - Transfer occurs when valid && ready at each boundary.
- Latency: 2 cycles from input transfer to outValid with no stall. One result per cycle sustained.
- Stall: with outReady=0, outputs hold stable and outValid stays 1. Up to 2 operands are buffered, then inReady=0. No loss, no duplication, order preserved.
- Simultaneous drain and fill of a full pipeline is permitted in the same cycle.
- No rounding or NaN/Inf arithmetic here. special is passed through for the exception path.
- Signed zero for exact cancellation is resolved downstream.

Test Plan:
- a=0x3F800000, b=0x3F800000, sub=0 -> after 2 cycles: eop=0, aExpIsSmall=0, bigExp=127, bigMant=0x800000, smallMant=0x4000000, special=0.
- a=0x3F800000, b=0xC0800000, sub=0 -> eop=1, aExpIsSmall=1, bSign=1, bigExp=129, smallMant=0x1000000.
- a=0x3F800000 (1.0), b=0x3FC00000 (1.5), sub=1 -> equal exponents, mantissa compare gives aExpIsSmall=1, eop=1, bSign=1, bigMant=0xC00000, smallMant=0x4000000.
- a=0x3F800001, b=0x4E800000 (diff 30) -> smallMant=27'd1 (sticky only). Also a=0x00000001, b=0x00800000 -> aExpIsSmall=1, diff=0, smallMant=0x0000008.
- Backpressure: 4 back-to-back valid inputs with outReady=0 -> inReady falls after 2 accepts, outputs stable. Release outReady -> results emerge in input order, one per cycle, none lost.
- Assert rst with 2 operands in flight -> outValid=0 immediately (async). After release, outputs are all zero and a new operation returns 2 cycles after acceptance.
